// File: rtl/gatorga_pkg.sv
// gatorga_pkg -- shared types and constants for the gatorga game pipeline.
//   bullet_state_t : player bullet FSM states
//   COLOR_BULLET   : bullet colour as {R,G,B}, one byte per channel
//   COLOR_BLACK    : background (nothing drawn)
//   SCREEN_W/H     : visible raster size in pixels
package gatorga_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } bullet_state_t;

  localparam logic [0:2][7:0] COLOR_BULLET = {8'hFF, 8'hFF, 8'h00};
  localparam logic [0:2][7:0] COLOR_BLACK  = {8'h00, 8'h00, 8'h00};

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/rise_detect.sv
// rise_detect -- registered rising-edge detector for a level input that is
// already synchronous to clk (e.g. a debounced button).
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset, clears the history register
//   d    : level input
//   rise : high for the single cycle in which d is high and was low on the
//          previous clock edge
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_prev_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_prev_reg <= 1'b0;
    end else begin
      d_prev_reg <= d;
    end
  end

  assign rise = d & ~d_prev_reg;

endmodule

// File: rtl/player_bullet.sv
// player_bullet -- single player bullet: launch on fire, climb one step per
// frame, retire at the top limit or when an alien consumes it, then a short
// cooldown before the next shot. Also renders the bullet into the raster.
//   pixel_clk     : sole clock
//   rst           : asynchronous active-low reset
//   fsync         : one-cycle frame-start pulse
//   fire          : fire button level
//   ship_x        : ship left column (signed)
//   hpos, vpos    : current raster position (signed)
//   alien_hit     : bullet consumed by the alien stage (pulse)
//   bullet_x/y    : bullet top-left corner
//   bullet_active : bullet in flight
//   pixel         : {R,G,B} bullet colour on bullet pixels, else black (1 cycle latency)
//   active        : raster is on the bullet (1 cycle latency)
//   shots_fired   : launch count, wraps at 16 bits
import gatorga_pkg::*;

module player_bullet #(
  parameter int BULLET_SPEED    = 8,
  parameter int BULLET_W        = 2,
  parameter int BULLET_H        = 8,
  parameter int SHIP_Y          = 440,
  parameter int X_OFFSET        = 7,
  parameter int TOP_LIMIT       = 0,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic                   pixel_clk,
  input  logic                   rst,
  input  logic                   fsync,
  input  logic                   fire,
  input  logic signed [11:0]     ship_x,
  input  logic signed [11:0]     hpos,
  input  logic signed [11:0]     vpos,
  input  logic                   alien_hit,
  output logic signed [11:0]     bullet_x,
  output logic signed [11:0]     bullet_y,
  output logic                   bullet_active,
  output logic [0:2][7:0]        pixel,
  output logic                   active,
  output logic [15:0]            shots_fired
);

  localparam logic signed [11:0] LAUNCH_Y = 12'(SHIP_Y - BULLET_H);
  localparam logic signed [11:0] X_OFF12  = 12'(X_OFFSET);
  // Vertical step and render bounds are evaluated one bit wider so that a
  // bullet near the top cannot wrap to a large positive row.
  localparam logic signed [12:0] SPEED13  = 13'(BULLET_SPEED);
  localparam logic signed [12:0] TOP13    = 13'(TOP_LIMIT);
  localparam logic signed [12:0] W13      = 13'(BULLET_W);
  localparam logic signed [12:0] H13      = 13'(BULLET_H);
  localparam logic [7:0]         CD_LOAD  = 8'(COOLDOWN_FRAMES);

  bullet_state_t          state_reg, state_next;
  logic                   fire_pending_reg, fire_pending_next;
  logic [7:0]             cooldown_reg, cooldown_next;
  logic signed [11:0]     bullet_x_reg, bullet_x_next;
  logic signed [11:0]     bullet_y_reg, bullet_y_next;
  logic                   bullet_active_reg, bullet_active_next;
  logic [15:0]            shots_reg, shots_next;
  logic                   active_reg, active_next;
  logic [0:2][7:0]        pixel_reg, pixel_next;

  logic                   fire_rise;
  logic signed [12:0]     y_step;
  logic signed [12:0]     bx13, by13, hx13, vy13;
  logic                   in_x, in_y;

  rise_detect u_fire_rise (
    .clk  (pixel_clk),
    .rst  (rst),
    .d    (fire),
    .rise (fire_rise)
  );

  assign y_step = 13'(bullet_y_reg) - SPEED13;

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= IDLE;
      fire_pending_reg  <= 1'b0;
      cooldown_reg      <= 8'd0;
      bullet_x_reg      <= 12'sd0;
      bullet_y_reg      <= 12'sd0;
      bullet_active_reg <= 1'b0;
      shots_reg         <= 16'd0;
      active_reg        <= 1'b0;
      pixel_reg         <= COLOR_BLACK;
    end else begin
      state_reg         <= state_next;
      fire_pending_reg  <= fire_pending_next;
      cooldown_reg      <= cooldown_next;
      bullet_x_reg      <= bullet_x_next;
      bullet_y_reg      <= bullet_y_next;
      bullet_active_reg <= bullet_active_next;
      shots_reg         <= shots_next;
      active_reg        <= active_next;
      pixel_reg         <= pixel_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    fire_pending_next  = fire_pending_reg;
    cooldown_next      = cooldown_reg;
    bullet_x_next      = bullet_x_reg;
    bullet_y_next      = bullet_y_reg;
    bullet_active_next = bullet_active_reg;
    shots_next         = shots_reg;

    case (state_reg)
      IDLE: begin
        if (fsync && fire_pending_reg) begin
          bullet_x_next      = ship_x + X_OFF12;
          bullet_y_next      = LAUNCH_Y;
          bullet_active_next = 1'b1;
          fire_pending_next  = 1'b0;
          shots_next         = shots_reg + 16'd1;
          state_next         = FLYING;
        end else if (fire_rise) begin
          fire_pending_next = 1'b1;
        end
      end

      FLYING: begin
        fire_pending_next = 1'b0;
        // A consumed bullet retires even if the frame step lands on the same edge.
        if (alien_hit || (fsync && (y_step < TOP13))) begin
          bullet_active_next = 1'b0;
          cooldown_next      = CD_LOAD;
          state_next         = COOLDOWN;
        end else if (fsync) begin
          bullet_y_next = y_step[11:0];
        end
      end

      COOLDOWN: begin
        fire_pending_next = 1'b0;
        if (cooldown_reg == 8'd0) begin
          state_next = IDLE;
        end else if (fsync) begin
          cooldown_next = cooldown_reg - 8'd1;
          if (cooldown_reg == 8'd1) begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Render: compare the raster against the current bullet box.
  always_comb begin
    bx13        = 13'(bullet_x_reg);
    by13        = 13'(bullet_y_reg);
    hx13        = 13'(hpos);
    vy13        = 13'(vpos);
    in_x        = (hx13 >= bx13) && (hx13 < bx13 + W13);
    in_y        = (vy13 >= by13) && (vy13 < by13 + H13);
    active_next = bullet_active_reg && in_x && in_y;
    pixel_next  = active_next ? COLOR_BULLET : COLOR_BLACK;
  end

  assign bullet_x      = bullet_x_reg;
  assign bullet_y      = bullet_y_reg;
  assign bullet_active = bullet_active_reg;
  assign shots_fired   = shots_reg;
  assign active        = active_reg;
  assign pixel         = pixel_reg;

endmodule
